dma_streamer: RTL and testbench

- Executes one stream request from the DMA control FSM, for one direction (read or write).
- Splits the descriptor (start address, byte count) into AXI-legal INCR burst requests and pushes them to the AXI interface request port with a valid/ready handshake.
- Returns a single-cycle done pulse to the FSM once every burst has been accepted.
- One instance serves the read path and one serves the write path.

---
 rtl/dma_streamer.sv | 137 +++++++++++++
 tb/tb_dma_streamer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_streamer.sv
// Splits one (address, byte count) descriptor into AXI INCR burst requests that never
// cross a 4KB page or exceed MAX_BEATS, then pulses done (with error flag) to the DMA FSM.
module dma_streamer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  str_valid_i,
    input  logic                  str_idx_i,
    input  logic [ADDR_WIDTH-1:0] desc_addr_i,
    input  logic [ADDR_WIDTH-1:0] desc_num_bytes_i,
    input  logic                  clear_i,
    output logic                  str_done_o,
    output logic                  str_err_o,
    output logic                  str_idx_o,
    output logic                  txn_valid_o,
    input  logic                  txn_ready_i,
    output logic [ADDR_WIDTH-1:0] txn_addr_o,
    output logic [7:0]            txn_len_o,
    output logic [2:0]            txn_size_o,
    output logic                  txn_last_o
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int SIZE       = $clog2(DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0] PAGE_BYTES = ADDR_WIDTH'(4096);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_BYTES - 1);

    // Valid/ready: txn_valid_o rises in REQ and holds addr/len/last stable until the
    // cycle txn_ready_i is also high; that edge is the handshake and valid drops after it.
    typedef enum logic [1:0] {IDLE, CALC, REQ, DONE} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q, rem_q, bytes_q;
    logic                    idx_q, done_seen_q;
    logic                    txn_valid_q, txn_last_q;
    logic [ADDR_WIDTH-1:0]   txn_addr_q;
    logic [7:0]              txn_len_q;
    logic                    str_done_q, str_err_q, str_idx_q;

    logic [ADDR_WIDTH-1:0]   rem_beats, page_beats, beats_d, bytes_d;
    logic                    misaligned;

    always_comb begin
        rem_beats  = rem_q >> SIZE;
        page_beats = (PAGE_BYTES - {{(ADDR_WIDTH-12){1'b0}}, addr_q[11:0]}) >> SIZE;
        beats_d    = ADDR_WIDTH'(MAX_BEATS);
        if (rem_beats < beats_d) beats_d = rem_beats;
        if (page_beats < beats_d) beats_d = page_beats;
        bytes_d    = beats_d << SIZE;
        misaligned = ((desc_addr_i | desc_num_bytes_i) & ALIGN_MASK) != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            bytes_q     <= '0;
            idx_q       <= 1'b0;
            done_seen_q <= 1'b0;
            txn_valid_q <= 1'b0;
            txn_last_q  <= 1'b0;
            txn_addr_q  <= '0;
            txn_len_q   <= '0;
            str_done_q  <= 1'b0;
            str_err_q   <= 1'b0;
            str_idx_q   <= 1'b0;
        end else begin
            str_done_q <= 1'b0;
            str_err_q  <= 1'b0;
            str_idx_q  <= 1'b0;
            if (clear_i) begin
                state_q     <= IDLE;
                txn_valid_q <= 1'b0;
                done_seen_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!str_valid_i) begin
                            done_seen_q <= 1'b0;
                        end else if (!done_seen_q) begin
                            addr_q <= desc_addr_i;
                            rem_q  <= desc_num_bytes_i;
                            idx_q  <= str_idx_i;
                            if (misaligned || desc_num_bytes_i == '0) begin
                                state_q     <= DONE;
                                str_done_q  <= 1'b1;
                                str_err_q   <= misaligned;
                                str_idx_q   <= str_idx_i;
                                done_seen_q <= 1'b1;
                            end else begin
                                state_q <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        txn_addr_q  <= addr_q;
                        txn_len_q   <= 8'(beats_d - ADDR_WIDTH'(1));
                        txn_last_q  <= (bytes_d == rem_q);
                        bytes_q     <= bytes_d;
                        txn_valid_q <= 1'b1;
                        state_q     <= REQ;
                    end
                    REQ: begin
                        if (txn_ready_i) begin
                            txn_valid_q <= 1'b0;
                            addr_q      <= addr_q + bytes_q;
                            rem_q       <= rem_q - bytes_q;
                            // last was computed as "this burst drains the remainder"
                            if (txn_last_q) begin
                                state_q     <= DONE;
                                str_done_q  <= 1'b1;
                                str_idx_q   <= idx_q;
                                done_seen_q <= 1'b1;
                            end else begin
                                state_q <= CALC;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign str_done_o  = str_done_q;
    assign str_err_o   = str_err_q;
    assign str_idx_o   = str_idx_q;
    assign txn_valid_o = txn_valid_q;
    assign txn_addr_o  = txn_addr_q;
    assign txn_len_o   = txn_len_q;
    assign txn_size_o  = 3'(SIZE);
    assign txn_last_o  = txn_last_q;

endmodule

// File: tb/tb_dma_streamer.sv
// Bench for dma_streamer: directed descriptor table, clear sequence and random
// descriptors, each checked against a byte-level burst-splitting model.
module tb_dma_streamer;
    logic        clk = 1'b0;
    logic        rst;
    logic        str_valid_i, str_idx_i, clear_i, txn_ready_i;
    logic [31:0] desc_addr_i, desc_num_bytes_i;
    logic        str_done_o, str_err_o, str_idx_o, txn_valid_o, txn_last_o;
    logic [31:0] txn_addr_o;
    logic [7:0]  txn_len_o;
    logic [2:0]  txn_size_o;

    int n_tests = 0;
    int n_fail  = 0;

    dma_streamer dut (
        .clk(clk), .rst(rst),
        .str_valid_i(str_valid_i), .str_idx_i(str_idx_i),
        .desc_addr_i(desc_addr_i), .desc_num_bytes_i(desc_num_bytes_i),
        .clear_i(clear_i),
        .str_done_o(str_done_o), .str_err_o(str_err_o), .str_idx_o(str_idx_o),
        .txn_valid_o(txn_valid_o), .txn_ready_i(txn_ready_i),
        .txn_addr_o(txn_addr_o), .txn_len_o(txn_len_o),
        .txn_size_o(txn_size_o), .txn_last_o(txn_last_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        last;
    } burst_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] nbytes;
        logic        idx;
        int          mode;      // 0: ready high (optional stall of burst 0), 1: random ready
        int          stall;
        int          exp_n;     // hand-derived burst count, -1 = unchecked
        logic        exp_err;
        int          exp_len0;  // hand-derived len of burst 0, -1 = unchecked
    } vec_t;

    burst_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte-level reference: take min(remaining, 2048 bytes, bytes to next 4KB page).
    task automatic build_model(input logic [31:0] a, input logic [31:0] nb);
        logic [31:0] cur, rem, room, take;
        exp_q.delete();
        cur = a;
        rem = nb;
        while (rem != 0) begin
            room = 32'd4096 - (cur % 32'd4096);
            take = rem;
            if (take > 32'd2048) take = 32'd2048;
            if (take > room) take = room;
            exp_q.push_back('{cur, 8'((take / 8) - 1), take == rem});
            cur = cur + take;
            rem = rem - take;
        end
    endtask

    task automatic run_req(input vec_t v);
        int          n_seen = 0, last_hs = -1, stall = 0;
        bit          done = 0, err;
        logic        pv = 0, phs = 0, plast = 0;
        logic [31:0] pa = '0;
        logic [7:0]  pl = '0;
        burst_t      b;
        err = (v.addr % 8 != 0) || (v.nbytes % 8 != 0);
        if (err) exp_q.delete();
        else build_model(v.addr, v.nbytes);
        @(negedge clk);
        str_valid_i = 1'b1;
        desc_addr_i = v.addr;
        desc_num_bytes_i = v.nbytes;
        str_idx_i = v.idx;
        txn_ready_i = 1'b0;
        for (int t = 1; t <= 3000 && !done; t++) begin
            @(negedge clk);
            desc_addr_i = $urandom;
            desc_num_bytes_i = $urandom;
            if (pv && !phs && txn_valid_o) begin
                chk("held_addr", txn_addr_o, pa);
                chk("held_len", txn_len_o, pl);
                chk("held_last", txn_last_o, plast);
            end
            if (pv && phs) chk("bubble_after_hs", txn_valid_o, 0);
            if (txn_valid_o && n_seen == 0 && !pv) chk("first_valid_cycle", t, 2);
            if (v.mode == 1) txn_ready_i = ($urandom_range(0, 3) != 0);
            else if (txn_valid_o && n_seen == 0 && stall < v.stall) begin
                txn_ready_i = 1'b0;
                stall++;
            end else txn_ready_i = 1'b1;
            pv = txn_valid_o; pa = txn_addr_o; pl = txn_len_o; plast = txn_last_o;
            phs = txn_valid_o && txn_ready_i;
            if (phs) begin
                if (exp_q.size() == 0) chk("extra_burst", 1, 0);
                else begin
                    b = exp_q.pop_front();
                    chk("burst_addr", txn_addr_o, b.addr);
                    chk("burst_len", txn_len_o, b.len);
                    chk("burst_last", txn_last_o, b.last);
                    chk("burst_size", txn_size_o, 3);
                    if (n_seen == 0 && v.exp_len0 >= 0) chk("first_len_table", txn_len_o, v.exp_len0);
                end
                n_seen++;
                last_hs = t;
            end
            if (str_done_o) begin
                done = 1;
                chk("done_err", str_err_o, err);
                chk("done_idx", str_idx_o, v.idx);
                chk("done_cycle", t, (err || v.nbytes == 0) ? 1 : last_hs + 1);
                chk("missing_bursts", exp_q.size(), 0);
                if (v.exp_n >= 0) chk("burst_count", n_seen, v.exp_n);
                if (v.exp_n >= 0) chk("err_table", str_err_o, v.exp_err);
            end
        end
        if (!done) chk("done_timeout", 0, 1);
        // valid stays high through the first IDLE cycle; no restart may follow
        @(negedge clk);
        chk("done_width", str_done_o, 0);
        str_valid_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no_restart_valid", txn_valid_o, 0);
            chk("no_restart_done", str_done_o, 0);
        end
    endtask

    vec_t vecs[$];
    vec_t rv;

    initial begin
        rst = 1'b1; str_valid_i = 0; str_idx_i = 0; clear_i = 0; txn_ready_i = 0;
        desc_addr_i = '0; desc_num_bytes_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", str_done_o, 0);
        chk("rst_err", str_err_o, 0);
        chk("rst_idx", str_idx_o, 0);
        chk("rst_valid", txn_valid_o, 0);
        chk("rst_addr", txn_addr_o, 0);
        chk("rst_len", txn_len_o, 0);
        chk("rst_last", txn_last_o, 0);
        chk("rst_size", txn_size_o, 3);
        rst = 1'b0;

        vecs.push_back('{32'h0000_1000, 32'd64,   1'b1, 0, 0, 1, 1'b0, 7});
        vecs.push_back('{32'h0000_0FF0, 32'd64,   1'b0, 0, 0, 2, 1'b0, 1});
        vecs.push_back('{32'h0000_0000, 32'd4096, 1'b1, 0, 0, 2, 1'b0, 255});
        vecs.push_back('{32'h0000_0FF0, 32'd64,   1'b0, 0, 5, 2, 1'b0, 1});
        vecs.push_back('{32'h0000_1004, 32'd64,   1'b1, 0, 0, 0, 1'b1, -1});
        vecs.push_back('{32'h0000_2000, 32'd0,    1'b0, 0, 0, 0, 1'b0, -1});
        vecs.push_back('{32'h0000_1000, 32'd60,   1'b1, 0, 0, 0, 1'b1, -1});
        vecs.push_back('{32'hFFFF_FFF0, 32'd64,   1'b1, 0, 0, 2, 1'b0, 1});
        vecs.push_back('{32'h0000_0F00, 32'd8192, 1'b0, 1, 0, 5, 1'b0, 31});
        for (int i = 0; i < vecs.size(); i++) run_req(vecs[i]);

        // clear while a burst is stalled in REQ
        @(negedge clk);
        str_valid_i = 1'b1; desc_addr_i = 32'h0FF0; desc_num_bytes_i = 32'd64; str_idx_i = 1'b1;
        txn_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("clr_valid_before", txn_valid_o, 1);
        clear_i = 1'b1;
        str_valid_i = 1'b0;
        @(negedge clk);
        clear_i = 1'b0;
        chk("clr_valid_after", txn_valid_o, 0);
        repeat (4) begin
            @(negedge clk);
            chk("clr_no_done", str_done_o, 0);
            chk("clr_no_valid", txn_valid_o, 0);
        end
        run_req('{32'h0000_3000, 32'd128, 1'b1, 0, 0, 1, 1'b0, 15});

        for (int i = 0; i < 25; i++) begin
            rv.addr = $urandom & 32'hFFFF_FFF8;
            if ($urandom_range(0, 7) == 0) rv.addr = rv.addr | 32'h4;
            rv.nbytes = 32'($urandom_range(0, 700)) * 8;
            if ($urandom_range(0, 9) == 0) rv.nbytes = rv.nbytes + 32'd3;
            rv.idx = 1'($urandom_range(0, 1));
            rv.mode = 1; rv.stall = 0; rv.exp_n = -1; rv.exp_err = 1'b0; rv.exp_len0 = -1;
            run_req(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
